bitserial_alu_ctrl: RTL and testbench
=====================================

BITSERIAL_ALU_CTRL -- requirements
Module: bitserial_alu_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, giving the operand/result width in bits (W >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 SHALL have port mode  input  2  operation class: 0 logic, 1 arithmetic with carry-in 0, 2 or 3 arithmetic with carry-in 1.
REQ-006 SHALL have port op  input  2  operation select within the mode.
REQ-007 SHALL have port a  input  W  operand A.
REQ-008 SHALL have port b  input  W  operand B.
REQ-009 SHALL have port slice_a  output  1  current A bit to the 1-bit ALU slice.
REQ-010 SHALL have port slice_b  output  1  current B bit to the slice.
REQ-011 SHALL have port slice_cin  output  1  carry into the slice.
REQ-012 SHALL have port slice_mode  output  2  latched mode to the slice.
REQ-013 SHALL have port slice_op  output  2  latched op to the slice.
REQ-014 SHALL have port slice_result  input  1  result bit returned by the slice.
REQ-015 SHALL have port slice_cout  input  1  carry out returned by the slice.
REQ-016 SHALL have port busy  output  1  high while bits are being sequenced.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the result is complete.
REQ-018 SHALL have port result  output  W  assembled result; held until the next accepted start.
REQ-019 SHALL have port cout  output  1  final carry out of bit W-1; 0 in mode 0.
REQ-020 SHALL have port ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB); 0 in mode 0.

Function
REQ-021 SHALL implement a three-state FSM, IDLE -> RUN -> DONE -> IDLE; start with busy=0 in IDLE or DONE moves to RUN.
REQ-022 On an accepted start, SHALL latch a, b, mode and op, clear the bit counter, and set the carry register to 1 if mode >= 2, else 0.
REQ-023 In RUN, slice_a and slice_b SHALL equal bit i of the latched A and B, and slice_cin SHALL equal the carry register, where i is the counter value (LSB first).
REQ-024 Each RUN edge SHALL capture slice_result as result bit i, load slice_cout into the carry register, and increment the counter.
REQ-025 In mode 0, SHALL drive slice_cin=0 and ignore slice_cout.
REQ-026 After the edge that captures bit W-1, SHALL enter DONE, assert done for exactly one cycle, and update cout and ovf.
REQ-027 done SHALL go high exactly W rising edges after the edge that sampled start.
REQ-028 start while busy=1 SHALL be ignored; latched operands, counter and outputs SHALL be unaffected.
REQ-029 Changes on a, b, mode or op after acceptance SHALL NOT affect the running operation.
REQ-030 result, cout and ovf SHALL change only at DONE entry and SHALL hold until the next DONE.
REQ-031 busy SHALL be 1 exactly in RUN; slice_mode and slice_op SHALL present the latched values at all times.
REQ-032 The counter SHALL be ceil(log2(W)) bits wide and SHALL NOT wrap while in RUN.
REQ-033 Outside RUN, slice_a, slice_b and slice_cin SHALL be 0.

Reset
REQ-034 reset=1 at a clock edge SHALL force IDLE and clear busy, done, result, cout, ovf, counter, carry register and latched operands to 0.
REQ-035 reset SHALL take priority over start and over an in-flight RUN; no done SHALL be emitted for an aborted operation.
REQ-036 The first start sampled with reset=0 after reset deasserts SHALL be accepted normally.

Verification (W=8, bench-provided slice model)
REQ-037 SHALL cover: mode=0, op=2, A=0x5A, B=0x3C -> done after 8 edges, result=0x66, cout=0, ovf=0.
REQ-038 SHALL cover: mode=1, op=2, A=0xFF, B=0x01 -> result=0x00, cout=1, ovf=0.
REQ-039 SHALL cover: mode=2, op=1, A=0x01 -> result=0xFF, cout=0.
REQ-040 SHALL cover: mode=2, op=3, A=0x03, B=0x10 -> result=0x0D, cout=1; and A=0x7F, B=0x01, mode=1, op=2 -> result=0x80, ovf=1.
REQ-041 SHALL cover: start pulsed again at RUN cycle 3 with different operands -> ignored; the original result appears on schedule.
REQ-042 SHALL cover: reset asserted at RUN cycle 4 -> IDLE next cycle, all outputs 0, no done pulse; a new start then completes correctly.

Source files
------------

// File: rtl/bitserial_alu_ctrl_if.sv
// Bundle between the bit-serial ALU sequencer, its requester and its external 1-bit ALU slice.
// The requester starts an operation when busy=0; the controller answers with a one-cycle done pulse, then holds the result.
interface bitserial_alu_ctrl_if #(parameter int W = 8);
   logic         start;
   logic [1:0]   mode;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         slice_a;
   logic         slice_b;
   logic         slice_cin;
   logic [1:0]   slice_mode;
   logic [1:0]   slice_op;
   logic         slice_result;
   logic         slice_cout;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic [1:0]   state_dbg;

   modport slave (
      input  start, mode, op, a, b, slice_result, slice_cout,
      output slice_a, slice_b, slice_cin, slice_mode, slice_op,
      output busy, done, result, cout, ovf, state_dbg
   );

   modport master (
      output start, mode, op, a, b, slice_result, slice_cout,
      input  slice_a, slice_b, slice_cin, slice_mode, slice_op,
      input  busy, done, result, cout, ovf, state_dbg
   );
endinterface

// File: rtl/bitserial_alu_ctrl.sv
// Sequences W-bit operands LSB-first through an external 1-bit ALU slice and assembles
// the result, final carry and signed overflow.
module bitserial_alu_ctrl #(
   parameter int W = 8
) (
   input logic               clk,
   input logic               reset,
   bitserial_alu_ctrl_if.slave bus
);
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_acc;
   logic [W-1:0]  r_result;
   logic [1:0]    r_mode;
   logic [1:0]    r_op;
   logic [CW-1:0] r_cnt;
   logic          r_carry;
   logic          r_cout;
   logic          r_ovf;

   logic          w_accept;
   logic          w_last;
   logic          w_arith;
   logic [W-1:0]  w_acc_next;
   logic          w_busy;
   logic          w_done;
   logic          w_slice_a;
   logic          w_slice_b;
   logic          w_slice_cin;

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = (r_cnt == LAST);
      w_arith      = (r_mode != 2'd0);
      w_acc_next   = r_acc;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_slice_a    = 1'b0;
      w_slice_b    = 1'b0;
      w_slice_cin  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            w_busy             = 1'b1;
            w_slice_a          = r_a[r_cnt];
            w_slice_b          = r_b[r_cnt];
            // Logic mode never propagates a carry, whatever the slice returns.
            w_slice_cin        = w_arith & r_carry;
            w_acc_next[r_cnt]  = bus.slice_result;
            if (w_last) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done = 1'b1;
            if (bus.start) begin
               w_accept     = 1'b1;
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_mode   <= '0;
         r_op     <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_mode  <= bus.mode;
            r_op    <= bus.op;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= bus.mode[1];
         end else if (r_state == ST_RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= w_arith & bus.slice_cout;
            // Carry into the MSB is r_carry while bit W-1 is in the slice.
            if (w_last) begin
               r_result <= w_acc_next;
               r_cout   <= w_arith & bus.slice_cout;
               r_ovf    <= w_arith & (bus.slice_cout ^ r_carry);
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign bus.slice_a    = w_slice_a;
   assign bus.slice_b    = w_slice_b;
   assign bus.slice_cin  = w_slice_cin;
   assign bus.slice_mode = r_mode;
   assign bus.slice_op   = r_op;
   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.result     = r_result;
   assign bus.cout       = r_cout;
   assign bus.ovf        = r_ovf;
   assign bus.state_dbg  = r_state;
endmodule

// File: tb/tb_bitserial_alu_ctrl.sv
// Randomized and directed bench for bitserial_alu_ctrl with a 1-bit slice model and a
// word-level arithmetic reference.
module tb_bitserial_alu_ctrl;
   localparam int W = 8;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   logic [W-1:0] exp_q[$];
   logic [1:0]   flag_q[$];
   logic [W-1:0] prev_res;
   logic [1:0]   prev_flags;

   bitserial_alu_ctrl_if #(.W(W)) bus ();

   bitserial_alu_ctrl #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1-bit ALU slice: op[0] inverts A, op[1] adds B; mode 0 is bitwise logic.
   always_comb begin
      logic xb;
      logic yb;
      xb = bus.slice_op[0] ? ~bus.slice_a : bus.slice_a;
      yb = bus.slice_op[1] ? bus.slice_b : 1'b0;
      bus.slice_result = 1'b0;
      bus.slice_cout   = 1'b0;
      if (bus.slice_mode == 2'd0) begin
         case (bus.slice_op)
            2'd0:    bus.slice_result = bus.slice_a & bus.slice_b;
            2'd1:    bus.slice_result = bus.slice_a | bus.slice_b;
            2'd2:    bus.slice_result = bus.slice_a ^ bus.slice_b;
            default: bus.slice_result = ~bus.slice_a;
         endcase
         bus.slice_cout = bus.slice_a;
      end else begin
         bus.slice_result = xb ^ yb ^ bus.slice_cin;
         bus.slice_cout   = (xb & yb) | (xb & bus.slice_cin) | (yb & bus.slice_cin);
      end
   end

   // word-level reference: returns {ovf, cout, result}
   function automatic logic [W+1:0] ref_model(input logic [1:0] m, input logic [1:0] o,
                                              input logic [W-1:0] av, input logic [W-1:0] bv);
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W:0]   sum;
      logic [W:0]   cin_w;
      logic [W-1:0] low;
      logic [W-1:0] cin_l;
      logic [W-2:0] xl;
      logic [W-2:0] yl;
      logic         co;
      if (m == 2'd0) begin
         case (o)
            2'd0:    x = av & bv;
            2'd1:    x = av | bv;
            2'd2:    x = av ^ bv;
            default: x = ~av;
         endcase
         return {2'b00, x};
      end
      x     = o[0] ? ~av : av;
      y     = o[1] ? bv : '0;
      cin_w = (m >= 2'd2) ? 1 : 0;
      cin_l = (m >= 2'd2) ? 1 : 0;
      sum   = {1'b0, x} + {1'b0, y} + cin_w;
      xl    = x[W-2:0];
      yl    = y[W-2:0];
      low   = {1'b0, xl} + {1'b0, yl} + cin_l;
      co    = sum[W];
      return {low[W-1] ^ co, co, sum[W-1:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_slice_a"}, 32'(bus.slice_a), 0);
      check({tag, "_slice_b"}, 32'(bus.slice_b), 0);
      check({tag, "_slice_cin"}, 32'(bus.slice_cin), 0);
   endtask

   task automatic scramble_inputs();
      bus.a    = W'($urandom);
      bus.b    = W'($urandom);
      bus.mode = 2'($urandom_range(0, 3));
      bus.op   = 2'($urandom_range(0, 3));
   endtask

   // driver: one full operation; disturb pulses a second start at RUN cycle 3
   task automatic run_op(input logic [1:0] m, input logic [1:0] o,
                         input logic [W-1:0] av, input logic [W-1:0] bv, input bit disturb);
      logic [W+1:0] e;
      logic [W-1:0] er;
      logic [1:0]   ef;
      e = ref_model(m, o, av, bv);
      exp_q.push_back(e[W-1:0]);
      flag_q.push_back(e[W+1:W]);
      @(negedge clk);
      bus.a = av; bus.b = bv; bus.mode = m; bus.op = o; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("run_busy0", 32'(bus.busy), 1);
      check("slice_a0", 32'(bus.slice_a), 32'(av[0]));
      check("slice_b0", 32'(bus.slice_b), 32'(bv[0]));
      check("slice_cin0", 32'(bus.slice_cin), (m >= 2'd2) ? 1 : 0);
      check("slice_mode", 32'(bus.slice_mode), 32'(m));
      check("slice_op", 32'(bus.slice_op), 32'(o));
      scramble_inputs();
      for (int k = 1; k <= W; k++) begin
         @(posedge clk);
         #1;
         if (k < W) begin
            check("run_done_low", 32'(bus.done), 0);
            check("run_busy", 32'(bus.busy), 1);
            check("run_slice_a", 32'(bus.slice_a), 32'(av[k]));
            check("run_slice_b", 32'(bus.slice_b), 32'(bv[k]));
            check("run_result_held", 32'(bus.result), 32'(prev_res));
            check("run_flags_held", 32'({bus.ovf, bus.cout}), 32'(prev_flags));
            if (m == 2'd0) check("logic_cin", 32'(bus.slice_cin), 0);
         end else begin
            er = exp_q.pop_front();
            ef = flag_q.pop_front();
            check("done_pulse", 32'(bus.done), 1);
            check("done_result", 32'(bus.result), 32'(er));
            check("done_cout", 32'(bus.cout), 32'(ef[0]));
            check("done_ovf", 32'(bus.ovf), 32'(ef[1]));
            check_idle_outputs("done");
            prev_res   = er;
            prev_flags = ef;
         end
         if (disturb && k == 3) begin
            scramble_inputs();
            bus.start = 1'b1;
         end
         if (disturb && k == 4) bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(bus.done), 0);
      check("result_hold", 32'(bus.result), 32'(prev_res));
   endtask

   // driver: start an operation, then reset it at RUN cycle 4
   task automatic abort_op(input logic [1:0] m, input logic [1:0] o,
                           input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      bus.a = av; bus.b = bv; bus.mode = m; bus.op = o; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_done", 32'(bus.done), 0);
      check("abort_result", 32'(bus.result), 0);
      check("abort_cout", 32'(bus.cout), 0);
      check("abort_ovf", 32'(bus.ovf), 0);
      check("abort_mode", 32'(bus.slice_mode), 0);
      check_idle_outputs("abort");
      prev_res   = '0;
      prev_flags = '0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < W + 2; k++) begin
         @(posedge clk);
         #1;
         check("abort_no_done", 32'(bus.done), 0);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      prev_res   = '0;
      prev_flags = '0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      bus.mode   = '0;
      bus.op     = '0;
      repeat (3) @(posedge clk);
      // start held during reset must not launch anything
      @(negedge clk);
      bus.a = 8'hA5; bus.b = 8'h5A; bus.mode = 2'd1; bus.op = 2'd2; bus.start = 1'b1;
      @(posedge clk);
      #1;
      check("reset_start_busy", 32'(bus.busy), 0);
      check("reset_done", 32'(bus.done), 0);
      check("reset_result", 32'(bus.result), 0);
      check("reset_cout", 32'(bus.cout), 0);
      check("reset_ovf", 32'(bus.ovf), 0);
      check_idle_outputs("reset");
      @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;

      run_op(2'd0, 2'd2, 8'h5A, 8'h3C, 1'b0);
      run_op(2'd1, 2'd2, 8'hFF, 8'h01, 1'b0);
      run_op(2'd2, 2'd1, 8'h01, 8'hC3, 1'b0);
      run_op(2'd2, 2'd3, 8'h03, 8'h10, 1'b0);
      run_op(2'd1, 2'd2, 8'h7F, 8'h01, 1'b0);
      run_op(2'd3, 2'd2, 8'h80, 8'h80, 1'b1);
      abort_op(2'd1, 2'd2, 8'h12, 8'h34);
      run_op(2'd1, 2'd2, 8'h12, 8'h34, 1'b0);

      for (int i = 0; i < 60; i++) begin
         run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
      end

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
